// File: rtl/uart_pkg.sv
// Shared definitions for the UART stages: state encoding, default baud divisor
// and frame-length constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DATA_BITS            = 8;
  localparam int FRAME_BITS           = 10;  // start + 8 data + stop
  localparam int FETCH_CYCLES         = 2;   // REQ + LOAD between frames

  function automatic int frame_period(input int clks_per_bit, input int parity_en);
    return (FRAME_BITS + parity_en) * clks_per_bit + FETCH_CYCLES;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = (cnt == LAST);

  // Wrap on the bit boundary itself so every bit lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a byte FIFO: pops one byte per frame and sends
// start, 8 data bits LSB first, optional even parity, stop.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_W       = DATA_BITS,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              tx_done,
  output logic [2:0]        state
);

  // FIFO handshake: fifo_rd is a one-cycle pop issued only when fifo_empty was
  // low at the decision edge; fifo_data is valid the cycle after fifo_rd.
  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_reg;
  logic              parity;
  logic [2:0]        bit_cnt;
  logic              bit_end;
  logic              baud_clr;
  logic              last_bit;
  logic              start_ok;

  assign start_ok = en && !fifo_empty;
  assign baud_clr = (state_q == ST_IDLE) || (state_q == ST_REQ) || (state_q == ST_LOAD);
  assign last_bit = (bit_cnt == 3'(DATA_W - 1));

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (baud_clr),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_ok) state_d = ST_REQ;
      ST_REQ:    state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_START;
      ST_START:  if (bit_end) state_d = ST_DATA;
      ST_DATA:   if (bit_end && last_bit) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP:   if (bit_end) state_d = start_ok ? ST_REQ : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      parity    <= 1'b0;
      bit_cnt   <= '0;
    end else if (state_q == ST_LOAD) begin
      shift_reg <= fifo_data;
      parity    <= ^fifo_data;
      bit_cnt   <= '0;
    end else if (state_q == ST_DATA && bit_end) begin
      shift_reg <= {1'b0, shift_reg[DATA_W-1:1]};
      bit_cnt   <= bit_cnt + 3'd1;
    end
  end

  // tx decodes straight from registers, so an async reset idles the line at once.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shift_reg[0];
      ST_PARITY: tx = parity;
      default:   tx = 1'b1;
    endcase
  end

  assign fifo_rd = (state_q == ST_REQ);
  assign busy    = (state_q != ST_IDLE);
  assign tx_done = (state_q == ST_STOP) && bit_end;
  assign state   = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: one instance without parity, one with, each fed by a
// behavioural FIFO and checked by a mid-bit sampling UART receiver model.
module tb_fifo_uart_tx;

  localparam int C       = 4;
  localparam int TIMEOUT = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       en_a = 1'b0, fifo_empty_a, fifo_rd_a, tx_a, busy_a, tx_done_a;
  logic [7:0] fifo_data_a = '0;
  logic [2:0] state_a;
  logic       en_p = 1'b0, fifo_empty_p, fifo_rd_p, tx_p, busy_p, tx_done_p;
  logic [7:0] fifo_data_p = '0;
  logic [2:0] state_p;

  int total = 0, bad = 0, cyc = 0;
  logic [7:0] exp_q[$];

  fifo_uart_tx #(.CLKS_PER_BIT(C), .DATA_W(8), .PARITY_EN(0)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .fifo_empty(fifo_empty_a), .fifo_data(fifo_data_a),
    .fifo_rd(fifo_rd_a), .tx(tx_a), .busy(busy_a), .tx_done(tx_done_a), .state(state_a)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(C), .DATA_W(8), .PARITY_EN(1)) dut_p (
    .clk(clk), .rst(rst), .en(en_p), .fifo_empty(fifo_empty_p), .fifo_data(fifo_data_p),
    .fifo_rd(fifo_rd_p), .tx(tx_p), .busy(busy_p), .tx_done(tx_done_p), .state(state_p)
  );

  // ---------------- behavioural FIFOs ----------------
  logic [7:0] mem_a[256];
  logic [7:0] mem_p[256];
  int wr_a = 0, rd_a = 0, wr_p = 0, rd_p = 0;
  assign fifo_empty_a = (wr_a == rd_a);
  assign fifo_empty_p = (wr_p == rd_p);

  always @(posedge clk) begin
    if (fifo_rd_a && wr_a != rd_a) begin
      fifo_data_a <= mem_a[rd_a % 256];
      rd_a        <= rd_a + 1;
    end
    if (fifo_rd_p && wr_p != rd_p) begin
      fifo_data_p <= mem_p[rd_p % 256];
      rd_p        <= rd_p + 1;
    end
  end

  task automatic push_a(input logic [7:0] b);
    mem_a[wr_a % 256] = b;
    wr_a++;
  endtask

  task automatic push_p(input logic [7:0] b);
    mem_p[wr_p % 256] = b;
    wr_p++;
  endtask

  // ---------------- monitors ----------------
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (fifo_rd_a) begin
      total++;
      if (fifo_empty_a) begin
        bad++;
        $display("FAIL underflow_a: fifo_rd=1 with fifo_empty=1, required no pop while empty");
      end
    end
    if (fifo_rd_p) begin
      total++;
      if (fifo_empty_p) begin
        bad++;
        $display("FAIL underflow_p: fifo_rd=1 with fifo_empty=1, required no pop while empty");
      end
    end
  end

  int rd_cnt_a = 0, done_cnt_a = 0, busy_drops = 0;
  int rd_times_a[$];
  int rd_times_p[$];
  bit watch_busy = 0;
  always @(negedge clk) begin
    if (fifo_rd_a) begin
      rd_cnt_a++;
      rd_times_a.push_back(cyc);
    end
    if (fifo_rd_p) rd_times_p.push_back(cyc);
    if (tx_done_a) done_cnt_a++;
    if (watch_busy && !busy_a) busy_drops++;
  end

  initial begin
    #(400000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- UART receiver model ----------------
  function automatic logic txv(input bit which);
    return which ? tx_p : tx_a;
  endfunction

  function automatic logic donev(input bit which);
    return which ? tx_done_p : tx_done_a;
  endfunction

  // Waits for a start bit, samples each slot mid-bit; len is the cycle count
  // from the first start cycle through the tx_done cycle.
  task automatic recv_frame(input bit which, input int drop_at, output logic [7:0] d,
                            output logic pbit, output logic sbit, output int len, output bit ok);
    int         nbits;
    bit         got;
    logic [10:0] bits;
    nbits = which ? 11 : 10;
    bits = '0; d = '0; pbit = 1'b0; sbit = 1'b0; len = 0; ok = 1'b0; got = 1'b0;
    for (int i = 0; i < TIMEOUT && !got; i++) begin
      @(negedge clk);
      if (txv(which) === 1'b0) got = 1'b1;
    end
    if (!got) return;
    for (int k = 0; k < nbits * C; k++) begin
      if (k > 0) @(negedge clk);
      if (k == drop_at) begin
        if (which) en_p = 1'b0;
        else       en_a = 1'b0;
      end
      if (k % C == C / 2) bits[k / C] = txv(which);
      if (donev(which) === 1'b1) len = k + 1;
    end
    d    = bits[8:1];
    pbit = bits[9];
    sbit = bits[nbits - 1];
    ok   = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] d; logic pb, sb; int len; bit ok;
    #1 rst = 1'b0;
    en_a = 1'b1;
    push_a(8'h5A);
    repeat (6) begin
      @(negedge clk);
      total++;
      if (tx_a !== 1'b1 || fifo_rd_a !== 1'b0 || busy_a !== 1'b0 || state_a !== 3'd0) begin
        bad++;
        $display("FAIL reset_hold: tx=%b rd=%b busy=%b state=%0d, required tx=1 rd=0 busy=0 state=0",
                 tx_a, fifo_rd_a, busy_a, state_a);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (fifo_rd_a !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_rd: fifo_rd=%b one cycle after release, required 1", fifo_rd_a);
    end
    @(negedge clk);
    total++;
    if (fifo_rd_a !== 1'b0) begin
      bad++;
      $display("FAIL rd_width: fifo_rd=%b on second cycle, required 0", fifo_rd_a);
    end
    recv_frame(0, -1, d, pb, sb, len, ok);
    total++;
    if ({ok, d, sb} !== {1'b1, 8'h5A, 1'b1}) begin
      bad++;
      $display("FAIL reset_frame: ok=%b data=%h stop=%b, required ok=1 data=5a stop=1", ok, d, sb);
    end
  endtask

  task automatic test_single_a5();
    logic [7:0] b;
    logic [9:0] frame;
    int r0, d0;
    bit got;
    repeat (3) @(negedge clk);
    r0 = rd_cnt_a; d0 = done_cnt_a;
    b = 8'hA5;
    frame = {1'b1, b, 1'b0};
    push_a(b);
    got = 1'b0;
    for (int i = 0; i < TIMEOUT && !got; i++) begin
      @(negedge clk);
      if (tx_a === 1'b0) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL a5_start: no start bit seen, required one within %0d cycles", TIMEOUT);
    end
    for (int k = 0; k < 10 * C; k++) begin
      if (k > 0) @(negedge clk);
      total++;
      if (tx_a !== frame[k / C] || tx_done_a !== (k == 10 * C - 1)) begin
        bad++;
        $display("FAIL a5_cycle %0d: tx=%b done=%b, required tx=%b done=%b",
                 k, tx_a, tx_done_a, frame[k / C], (k == 10 * C - 1));
      end
    end
    repeat (10) @(negedge clk);
    total++;
    if (rd_cnt_a - r0 !== 1 || done_cnt_a - d0 !== 1) begin
      bad++;
      $display("FAIL a5_counts: rd pulses=%0d done pulses=%0d, required 1 and 1",
               rd_cnt_a - r0, done_cnt_a - d0);
    end
    total++;
    if (fifo_rd_a !== 1'b0 || busy_a !== 1'b0 || state_a !== 3'd0) begin
      bad++;
      $display("FAIL a5_idle: rd=%b busy=%b state=%0d, required 0 0 0", fifo_rd_a, busy_a, state_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, e; logic pb, sb; int len; bit ok, got;
    rd_times_a.delete();
    busy_drops = 0;
    push_a(8'h00); exp_q.push_back(8'h00);
    push_a(8'hFF); exp_q.push_back(8'hFF);
    push_a(8'h3C); exp_q.push_back(8'h3C);
    got = 1'b0;
    for (int i = 0; i < TIMEOUT && !got; i++) begin
      @(negedge clk);
      if (fifo_rd_a === 1'b1) got = 1'b1;
    end
    watch_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      recv_frame(0, -1, d, pb, sb, len, ok);
      e = exp_q.pop_front();
      total++;
      if ({ok, d, sb} !== {1'b1, e, 1'b1}) begin
        bad++;
        $display("FAIL b2b_frame %0d: ok=%b data=%h stop=%b, required ok=1 data=%h stop=1", i, ok, d, sb, e);
      end
    end
    watch_busy = 1'b0;
    total++;
    if (busy_drops !== 0) begin
      bad++;
      $display("FAIL b2b_busy: busy low for %0d cycles between frames, required 0", busy_drops);
    end
    total++;
    if (rd_times_a.size() !== 3) begin
      bad++;
      $display("FAIL b2b_rd_count: %0d pops, required 3", rd_times_a.size());
    end else if (rd_times_a[1] - rd_times_a[0] !== 10 * C + 2 || rd_times_a[2] - rd_times_a[1] !== 10 * C + 2) begin
      bad++;
      $display("FAIL b2b_spacing: gaps %0d,%0d cycles, required %0d", rd_times_a[1] - rd_times_a[0],
               rd_times_a[2] - rd_times_a[1], 10 * C + 2);
    end
  endtask

  task automatic test_parity();
    logic [7:0] d; logic pb, sb; int len; bit ok;
    logic [7:0] bytes[2];
    bytes[0] = 8'h07; bytes[1] = 8'h03;
    rd_times_p.delete();
    en_p = 1'b1;
    push_p(bytes[0]);
    push_p(bytes[1]);
    for (int i = 0; i < 2; i++) begin
      recv_frame(1, -1, d, pb, sb, len, ok);
      total++;
      if ({ok, d, pb, sb} !== {1'b1, bytes[i], 1'($countones(bytes[i]) % 2), 1'b1} || len !== 11 * C) begin
        bad++;
        $display("FAIL parity_frame %0d: ok=%b data=%h par=%b stop=%b len=%0d, required data=%h par=%0d stop=1 len=%0d",
                 i, ok, d, pb, sb, len, bytes[i], $countones(bytes[i]) % 2, 11 * C);
      end
    end
    total++;
    if (rd_times_p.size() !== 2 || rd_times_p[1] - rd_times_p[0] !== 11 * C + 2) begin
      bad++;
      $display("FAIL parity_spacing: pops=%0d, required 2 pops %0d cycles apart", rd_times_p.size(), 11 * C + 2);
    end
    en_p = 1'b0;
  endtask

  task automatic test_en_drop();
    logic [7:0] d; logic pb, sb; int len; bit ok;
    int r0;
    repeat (3) @(negedge clk);
    r0 = rd_cnt_a;
    en_a = 1'b1;
    push_a(8'h55); push_a(8'h11); push_a(8'h22);
    recv_frame(0, 5 * C + 1, d, pb, sb, len, ok);
    total++;
    if ({ok, d, sb} !== {1'b1, 8'h55, 1'b1}) begin
      bad++;
      $display("FAIL en_drop_frame: ok=%b data=%h stop=%b, required ok=1 data=55 stop=1", ok, d, sb);
    end
    repeat (20) @(negedge clk);
    total++;
    if (rd_cnt_a - r0 !== 1 || state_a !== 3'd0 || busy_a !== 1'b0 || wr_a - rd_a !== 2) begin
      bad++;
      $display("FAIL en_drop_idle: pops=%0d state=%0d busy=%b queued=%0d, required 1 0 0 2",
               rd_cnt_a - r0, state_a, busy_a, wr_a - rd_a);
    end
    en_a = 1'b1;
    recv_frame(0, -1, d, pb, sb, len, ok);
    total++;
    if ({ok, d, sb} !== {1'b1, 8'h11, 1'b1}) begin
      bad++;
      $display("FAIL en_resume_1: ok=%b data=%h, required ok=1 data=11", ok, d);
    end
    recv_frame(0, -1, d, pb, sb, len, ok);
    total++;
    if ({ok, d, sb} !== {1'b1, 8'h22, 1'b1}) begin
      bad++;
      $display("FAIL en_resume_2: ok=%b data=%h, required ok=1 data=22", ok, d);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; logic pb, sb; int len; bit ok, got;
    int r0;
    repeat (3) @(negedge clk);
    r0 = rd_cnt_a;
    push_a(8'h0F); push_a(8'h77);
    got = 1'b0;
    for (int i = 0; i < TIMEOUT && !got; i++) begin
      @(negedge clk);
      if (tx_a === 1'b0) got = 1'b1;
    end
    repeat (6 * C) @(negedge clk);
    total++;
    if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
      bad++;
      $display("FAIL mid_bit5: tx=%b busy=%b in data bit 5 of 0f, required tx=0 busy=1", tx_a, busy_a);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || fifo_rd_a !== 1'b0 || state_a !== 3'd0) begin
      bad++;
      $display("FAIL mid_async: tx=%b busy=%b rd=%b state=%0d before any edge, required 1 0 0 0",
               tx_a, busy_a, fifo_rd_a, state_a);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    recv_frame(0, -1, d, pb, sb, len, ok);
    total++;
    if ({ok, d, sb} !== {1'b1, 8'h77, 1'b1}) begin
      bad++;
      $display("FAIL mid_next: ok=%b data=%h stop=%b, required ok=1 data=77 stop=1", ok, d, sb);
    end
    repeat (10) @(negedge clk);
    total++;
    if (rd_cnt_a - r0 !== 2 || wr_a !== rd_a || state_a !== 3'd0) begin
      bad++;
      $display("FAIL mid_no_resend: pops=%0d queued=%0d state=%0d, required 2 0 0",
               rd_cnt_a - r0, wr_a - rd_a, state_a);
    end
  endtask

  task automatic test_random();
    logic [7:0] d, e, b; logic pb, sb; int len, n; bit ok;
    en_a = 1'b1;
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom_range(0, 255));
        push_a(b);
        exp_q.push_back(b);
      end
      for (int j = 0; j < n; j++) begin
        recv_frame(0, -1, d, pb, sb, len, ok);
        e = exp_q.pop_front();
        total++;
        if ({ok, d, sb} !== {1'b1, e, 1'b1}) begin
          bad++;
          $display("FAIL rand_frame %0d.%0d: ok=%b data=%h stop=%b, required ok=1 data=%h stop=1",
                   r, j, ok, d, sb, e);
        end
      end
    end
    en_p = 1'b1;
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      b = 8'($urandom_range(0, 255));
      push_p(b);
      recv_frame(1, -1, d, pb, sb, len, ok);
      total++;
      if ({ok, d, pb, sb} !== {1'b1, b, 1'($countones(b) % 2), 1'b1}) begin
        bad++;
        $display("FAIL rand_parity %0d: ok=%b data=%h par=%b stop=%b, required data=%h par=%0d stop=1",
                 r, ok, d, pb, sb, b, $countones(b) % 2);
      end
    end
    en_p = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_parity();
    test_en_drop();
    test_reset_mid();
    test_random();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
